// File: rtl/wb_mailbox_pkg.sv
// ---------------------------------------------------------------------------
// wb_mailbox_pkg
// Shared definitions for the test-mailbox Wishbone responder and its
// console FIFO: register byte offsets inside the 16-byte window, STATUS
// bit positions, the two verdict codes software writes to the mailbox,
// and the bus-side state machine encoding.
// ---------------------------------------------------------------------------
package wb_mailbox_pkg;

   // Register byte offsets inside the window (word aligned)
   localparam logic [3:0] OFF_MAILBOX  = 4'h0;
   localparam logic [3:0] OFF_STATUS   = 4'h4;
   localparam logic [3:0] OFF_CYCLE_LO = 4'h8;
   localparam logic [3:0] OFF_CYCLE_HI = 4'hC;

   // STATUS register bit positions
   localparam int STAT_DONE    = 0;
   localparam int STAT_PASS    = 1;
   localparam int STAT_FAIL    = 2;
   localparam int STAT_TIMEOUT = 3;
   localparam int STAT_FULL    = 4;
   localparam int STAT_CNT_LSB = 8;
   localparam int STAT_CNT_W   = 8;

   // Mailbox bytes that end the test instead of reaching the console
   localparam logic [7:0] PASS_CODE = 8'h01;
   localparam logic [7:0] FAIL_CODE = 8'hFF;

   // Bus-side state machine
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACK   = 2'd1,
      ST_STALL = 2'd2
   } mbox_state_t;

   // A mailbox byte is either a verdict code or a console character
   function automatic logic is_verdict_code(input logic [7:0] b);
      return (b == PASS_CODE) || (b == FAIL_CODE);
   endfunction

endpackage

// File: rtl/wb_mailbox_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO used for the console bytes.
// The head entry is presented on pop_data whenever the FIFO is not empty
// and reads as zero when it is empty. Pushes into a full FIFO and pops
// from an empty one are ignored.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data this cycle (ignored when full)
//   push_data    WIDTH-bit entry to store
//   pop          drop the head entry this cycle (ignored when empty)
//   pop_data     head entry (FWFT), zero when empty
//   full, empty  occupancy flags
//   count        number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign pop_data = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy bookkeeping; a simultaneous push and pop
   // leaves the count unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care until written because the
   // output is masked while empty
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/wb_mailbox.sv
// ---------------------------------------------------------------------------
// wb_mailbox
// Wishbone B4 classic responder for the CPU test mailbox. Stores to the
// MAILBOX register become console bytes or a sticky pass/fail verdict,
// a free-running 64-bit cycle counter can be read in two halves, and a
// watchdog declares a timeout if software never reports a verdict.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   wb_cyc_i, wb_stb_i  Wishbone cycle / strobe
//   wb_we_i             write enable
//   wb_adr_i[31:0]      byte address; window is BASE_ADDR[31:4]
//   wb_dat_i[31:0]      write data (MAILBOX uses byte lane 0 only)
//   wb_sel_i[3:0]       byte lanes
//   wb_dat_o[31:0]      read data, valid only while wb_ack_o is high
//   wb_ack_o            one-cycle acknowledge
//   con_valid_o         console byte available
//   con_data_o[7:0]     console byte (FIFO head)
//   con_ready_i         consumer takes the byte when high with con_valid_o
//   done_o, pass_o, fail_o, timeout_o   sticky verdict flags
//
// Register map (byte offsets)
//   0x0 MAILBOX  W  01 -> pass, FF -> fail, else console byte; reads 0
//   0x4 STATUS   R  {count[15:8], full, timeout, fail, pass, done}
//   0x8 CYCLE_LO R  counter[31:0], snapshots counter[63:32]
//   0xC CYCLE_HI R  snapshot taken by the last CYCLE_LO read
// ---------------------------------------------------------------------------
module wb_mailbox
   import wb_mailbox_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 16,
   parameter int          MAX_CYCLES = 500_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        con_valid_o,
   output logic [7:0]  con_data_o,
   input  logic        con_ready_i,
   output logic        done_o,
   output logic        pass_o,
   output logic        fail_o,
   output logic        timeout_o
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   mbox_state_t      state;
   logic [63:0]      cycle_cnt;
   logic [31:0]      cycle_hi_shadow;
   logic [7:0]       stall_byte;

   logic             hit;
   logic [3:0]       reg_off;
   logic [7:0]       wr_byte;
   logic             timeout_hit;
   logic             verdict_open;
   logic             mbox_wr;
   logic             mbox_char;
   logic             lo_read;

   logic             fifo_push;
   logic [7:0]       fifo_push_data;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   logic [31:0]      status_word;
   logic [31:0]      rd_data;

   logic             unused_bits;

   // Address decode: only the upper 28 bits select the window, bits [3:2]
   // pick the register and the byte offset within a word is ignored
   assign hit     = wb_cyc_i & wb_stb_i & (wb_adr_i[31:4] == BASE_ADDR[31:4]);
   assign reg_off = {wb_adr_i[3:2], 2'b00};
   assign wr_byte = wb_dat_i[7:0];

   // The watchdog fires in the same cycle the counter reaches the limit.
   // It takes priority over a mailbox write landing in that cycle, so the
   // mailbox is treated as closed whenever a timeout is being recorded.
   assign timeout_hit  = (MAX_CYCLES != 0) && (cycle_cnt == 64'(MAX_CYCLES)) && !done_o;
   assign verdict_open = !done_o && !timeout_hit;

   // A mailbox store that still matters: lane 0 enabled, no verdict yet
   assign mbox_wr   = (state == ST_IDLE) && hit && wb_we_i && wb_sel_i[0] &&
                      (reg_off == OFF_MAILBOX) && verdict_open;
   assign mbox_char = mbox_wr && !is_verdict_code(wr_byte);
   assign lo_read   = (state == ST_IDLE) && hit && !wb_we_i && (reg_off == OFF_CYCLE_LO);

   // FIFO push request: straight from the bus in IDLE when there is room,
   // or the parked byte from a stall once a slot frees up. A stalled byte
   // is dropped if the master walks away or the verdict closes meanwhile.
   always_comb begin
      fifo_push      = 1'b0;
      fifo_push_data = wr_byte;
      case (state)
         ST_IDLE: begin
            fifo_push = mbox_char && !fifo_full;
         end
         ST_STALL: begin
            fifo_push_data = stall_byte;
            fifo_push      = wb_cyc_i && wb_stb_i && verdict_open && !fifo_full;
         end
         default: begin
            fifo_push = 1'b0;
         end
      endcase
   end

   // STATUS register image
   always_comb begin
      status_word                               = '0;
      status_word[STAT_DONE]                    = done_o;
      status_word[STAT_PASS]                    = pass_o;
      status_word[STAT_FAIL]                    = fail_o;
      status_word[STAT_TIMEOUT]                 = timeout_o;
      status_word[STAT_FULL]                    = fifo_full;
      status_word[STAT_CNT_LSB +: STAT_CNT_W]   = STAT_CNT_W'(fifo_count);
   end

   // Read data for the access being sampled; writes return zero
   always_comb begin
      rd_data = '0;
      if (!wb_we_i) begin
         case (reg_off)
            OFF_STATUS:   rd_data = status_word;
            OFF_CYCLE_LO: rd_data = cycle_cnt[31:0];
            OFF_CYCLE_HI: rd_data = cycle_hi_shadow;
            default:      rd_data = '0;
         endcase
      end
   end

   // Bus state machine with registered ack and read data. A request is
   // only sampled in IDLE, so every access costs at least two cycles.
   // A console byte that finds the FIFO full is parked in STALL until the
   // consumer frees a slot; the ack then follows the push by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         wb_ack_o   <= 1'b0;
         wb_dat_o   <= '0;
         stall_byte <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               wb_ack_o <= 1'b0;
               wb_dat_o <= '0;
               if (hit) begin
                  if (mbox_char && fifo_full) begin
                     state      <= ST_STALL;
                     stall_byte <= wr_byte;
                  end else begin
                     state    <= ST_ACK;
                     wb_ack_o <= 1'b1;
                     wb_dat_o <= rd_data;
                  end
               end
            end
            ST_STALL: begin
               wb_ack_o <= 1'b0;
               wb_dat_o <= '0;
               if (!(wb_cyc_i && wb_stb_i)) begin
                  state <= ST_IDLE;
               end else if (!verdict_open || !fifo_full) begin
                  state    <= ST_ACK;
                  wb_ack_o <= 1'b1;
               end
            end
            ST_ACK: begin
               state    <= ST_IDLE;
               wb_ack_o <= 1'b0;
               wb_dat_o <= '0;
            end
            default: begin
               state    <= ST_IDLE;
               wb_ack_o <= 1'b0;
               wb_dat_o <= '0;
            end
         endcase
      end
   end

   // Free-running cycle counter, the CYCLE_HI snapshot, and the sticky
   // verdict flags. Reading CYCLE_LO freezes the upper half so software
   // gets a coherent 64-bit value even if the low half wraps in between.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt       <= '0;
         cycle_hi_shadow <= '0;
         done_o          <= 1'b0;
         pass_o          <= 1'b0;
         fail_o          <= 1'b0;
         timeout_o       <= 1'b0;
      end else begin
         cycle_cnt <= cycle_cnt + 64'd1;
         if (lo_read) cycle_hi_shadow <= cycle_cnt[63:32];
         if (timeout_hit) begin
            done_o    <= 1'b1;
            timeout_o <= 1'b1;
         end else if (mbox_wr) begin
            if (wr_byte == PASS_CODE) begin
               done_o <= 1'b1;
               pass_o <= 1'b1;
            end else if (wr_byte == FAIL_CODE) begin
               done_o <= 1'b1;
               fail_o <= 1'b1;
            end
         end
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_con_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (con_ready_i),
      .pop_data  (con_data_o),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign con_valid_o = ~fifo_empty;

   // Bus bits that carry no meaning for this block
   assign unused_bits = ^{wb_sel_i[3:1], wb_dat_i[31:8], wb_adr_i[1:0]};

endmodule

// File: tb/tb_wb_mailbox.sv
// ---------------------------------------------------------------------------
// tb_wb_mailbox
// Self-checking bench for wb_mailbox. A behavioural model (cycle count
// since reset, expected console byte queue, verdict flags) predicts every
// bus read, console byte and flag; random console traffic, lane masks,
// out-of-window accesses and the stall / timeout corner cases are driven
// through a single bus task.
// ---------------------------------------------------------------------------
module tb_wb_mailbox;

   localparam logic [31:0] BASE  = 32'h1000_0000;
   localparam int          DEPTH = 16;
   localparam int          MAXC  = 300;

   localparam logic [3:0]  R_MB  = 4'h0;
   localparam logic [3:0]  R_ST  = 4'h4;
   localparam logic [3:0]  R_LO  = 4'h8;
   localparam logic [3:0]  R_HI  = 4'hC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_cyc_i = 1'b0;
   logic        wb_stb_i = 1'b0;
   logic        wb_we_i = 1'b0;
   logic [31:0] wb_adr_i = '0;
   logic [31:0] wb_dat_i = '0;
   logic [3:0]  wb_sel_i = '0;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        con_valid_o;
   logic [7:0]  con_data_o;
   logic        con_ready_i = 1'b0;
   logic        done_o, pass_o, fail_o, timeout_o;

   int          checks = 0;
   int          errors = 0;

   // Reference model state
   logic [63:0] model_cycles = '0;
   logic [31:0] model_shadow = '0;
   logic [7:0]  exp_q[$];
   logic        m_done = 1'b0, m_pass = 1'b0, m_fail = 1'b0, m_timeout = 1'b0;
   int          ready_mode = 0;

   always #5 clk = ~clk;

   wb_mailbox #(
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (DEPTH),
      .MAX_CYCLES (MAXC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wb_cyc_i    (wb_cyc_i),
      .wb_stb_i    (wb_stb_i),
      .wb_we_i     (wb_we_i),
      .wb_adr_i    (wb_adr_i),
      .wb_dat_i    (wb_dat_i),
      .wb_sel_i    (wb_sel_i),
      .wb_dat_o    (wb_dat_o),
      .wb_ack_o    (wb_ack_o),
      .con_valid_o (con_valid_o),
      .con_data_o  (con_data_o),
      .con_ready_i (con_ready_i),
      .done_o      (done_o),
      .pass_o      (pass_o),
      .fail_o      (fail_o),
      .timeout_o   (timeout_o)
   );

   // The counter advances once per clock from reset
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_cycles <= '0;
      else        model_cycles <= model_cycles + 64'd1;
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Console consumer: chooses ready for the coming edge and scoreboards
   // every byte that will be taken on it
   always @(negedge clk) begin
      case (ready_mode)
         0:       con_ready_i = 1'b0;
         1:       con_ready_i = 1'b1;
         default: con_ready_i = 1'($urandom_range(0, 1));
      endcase
      if (rst_n && con_valid_o && con_ready_i) begin
         if (exp_q.size() == 0) begin
            checkOutput("con_unexpected", 64'(con_valid_o), 64'd0);
         end else begin
            checkOutput("con_data", 64'(con_data_o), 64'(exp_q[0]));
            void'(exp_q.pop_front());
         end
      end
   end

   function automatic logic [31:0] statusModel(input int cnt);
      return {16'd0, 8'(cnt), 3'd0, (cnt == DEPTH), m_timeout, m_fail, m_pass, m_done};
   endfunction

   // One Wishbone access, called at a falling edge. Waits up to 'bound'
   // cycles for ack, then idles one cycle and confirms ack was one cycle.
   task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input int bound,
                                output logic [31:0] rdata, output logic acked,
                                output int waited, output logic [63:0] sampled);
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = we;
      wb_adr_i = adr;
      wb_dat_i = dat;
      wb_sel_i = sel;
      sampled  = model_cycles;
      acked    = 1'b0;
      rdata    = '0;
      waited   = 0;
      while (!acked && waited < bound) begin
         @(negedge clk);
         waited++;
         if (wb_ack_o) begin
            acked = 1'b1;
            rdata = wb_dat_o;
         end
      end
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      @(negedge clk);
      if (acked) checkOutput("ack_one_cycle", 64'(wb_ack_o), 64'd0);
   endtask

   task automatic regRead(input logic [3:0] off, output logic [31:0] data, output logic [63:0] cnt);
      logic ack;
      int   w;
      applyStimulus(1'b0, BASE | {28'd0, off}, 32'd0, 4'hF, 20, data, ack, w, cnt);
      checkOutput("rd_ack", 64'(ack), 64'd1);
   endtask

   task automatic regWrite(input logic [3:0] off, input logic [31:0] dat, input logic [3:0] sel,
                           output int waited);
      logic [31:0] rd;
      logic        ack;
      logic [63:0] c;
      applyStimulus(1'b1, BASE | {28'd0, off}, dat, sel, 200, rd, ack, waited, c);
      checkOutput("wr_ack", 64'(ack), 64'd1);
      checkOutput("wr_dat_zero", 64'(rd), 64'd0);
   endtask

   // Mailbox store with its expected effect on the model
   task automatic mboxWrite(input logic [7:0] b, input logic [3:0] sel, output int waited);
      if (sel[0] && !m_done) begin
         if (b == 8'h01) begin
            m_done = 1'b1;
            m_pass = 1'b1;
         end else if (b == 8'hFF) begin
            m_done = 1'b1;
            m_fail = 1'b1;
         end else begin
            exp_q.push_back(b);
         end
      end
      regWrite(R_MB, {24'($urandom), b}, sel, waited);
   endtask

   task automatic doReset();
      rst_n    = 1'b0;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      exp_q.delete();
      m_done = 1'b0; m_pass = 1'b0; m_fail = 1'b0; m_timeout = 1'b0;
      model_shadow = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic waitDrain(input string tag);
      int n;
      ready_mode = 1;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, 64'(exp_q.size()), 64'd0);
      repeat (2) @(negedge clk);
      checkOutput({tag, "_valid"}, 64'(con_valid_o), 64'd0);
   endtask

   task automatic fillFifo();
      int w;
      for (int i = 0; i < DEPTH; i++) mboxWrite(8'($urandom_range(2, 254)), 4'b0001, w);
   endtask

   // Starts the extra store that cannot fit and leaves it pending on the bus
   task automatic startStalledWrite(input logic [7:0] b);
      exp_q.push_back(b);
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = 1'b1;
      wb_adr_i = BASE | {28'd0, R_MB};
      wb_dat_i = {24'd0, b};
      wb_sel_i = 4'b0001;
   endtask

   initial begin
      #400000;
      errors++;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] simulation timed out");
   end

   initial begin
      logic [31:0] rd;
      logic [63:0] cnt;
      logic        ack;
      logic        seen;
      int          w;
      logic [7:0]  b;
      logic [3:0]  sel;

      // Reset values while rst_n is held low
      #1;
      checkOutput("reset_ack", 64'(wb_ack_o), 64'd0);
      checkOutput("reset_dat", 64'(wb_dat_o), 64'd0);
      checkOutput("reset_con", {55'd0, con_valid_o, con_data_o}, 64'd0);
      checkOutput("reset_flags", {60'd0, done_o, pass_o, fail_o, timeout_o}, 64'd0);

      // Console byte, lane masking, pass verdict, post-verdict stores
      $display("[TB] console and pass verdict");
      doReset();
      ready_mode = 1;
      mboxWrite(8'h41, 4'b0001, w);
      checkOutput("ack_latency", 64'(w), 64'd1);
      regRead(R_ST, rd, cnt);
      checkOutput("status_after_byte", 64'(rd), 64'(statusModel(0)));
      regRead(R_MB, rd, cnt);
      checkOutput("mailbox_reads_zero", 64'(rd), 64'd0);
      mboxWrite(8'h01, 4'b1110, w);
      checkOutput("lane0_off_no_verdict", 64'(done_o), 64'(m_done));
      mboxWrite(8'h01, 4'b0001, w);
      checkOutput("pass_flags", {62'd0, done_o, pass_o}, {62'd0, m_done, m_pass});
      regRead(R_ST, rd, cnt);
      checkOutput("status_pass", 64'(rd), 64'(statusModel(0)));
      ready_mode = 0;
      mboxWrite(8'hFF, 4'b0001, w);
      mboxWrite(8'h42, 4'b0001, w);
      regRead(R_ST, rd, cnt);
      checkOutput("status_sticky", 64'(rd), 64'(statusModel(0)));
      checkOutput("fail_stays_low", 64'(fail_o), 64'd0);
      regWrite(R_ST, 32'hFFFF_FFFF, 4'hF, w);
      regRead(R_HI, rd, cnt);
      checkOutput("cycle_hi_initial", 64'(rd), 64'(model_shadow));
      regRead(R_LO, rd, cnt);
      checkOutput("cycle_lo", 64'(rd), 64'(cnt[31:0]));
      model_shadow = cnt[63:32];
      regRead(R_HI, rd, cnt);
      checkOutput("cycle_hi_shadow", 64'(rd), 64'(model_shadow));

      // Full FIFO, stalled store, release by the consumer
      $display("[TB] full fifo stall");
      doReset();
      ready_mode = 0;
      fillFifo();
      regRead(R_ST, rd, cnt);
      checkOutput("status_full", 64'(rd), 64'(statusModel(DEPTH)));
      startStalledWrite(8'hA5);
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (wb_ack_o) seen = 1'b1;
      end
      checkOutput("stall_no_ack", 64'(seen), 64'd0);
      @(posedge clk);
      ready_mode = 1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("stall_ack_early", 64'(wb_ack_o), 64'd0);
      @(negedge clk);
      checkOutput("stall_ack_2cyc", 64'(wb_ack_o), 64'd1);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      @(negedge clk);
      checkOutput("stall_ack_one_cycle", 64'(wb_ack_o), 64'd0);
      waitDrain("stall_drain");
      regRead(R_ST, rd, cnt);
      checkOutput("status_drained", 64'(rd), 64'(statusModel(0)));

      // Reset asserted in the middle of a stall
      $display("[TB] reset during stall");
      doReset();
      ready_mode = 0;
      fillFifo();
      startStalledWrite(8'h5A);
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_stall_ack", 64'(wb_ack_o), 64'd0);
      checkOutput("rst_stall_con", 64'(con_valid_o), 64'd0);
      checkOutput("rst_stall_flags", {60'd0, done_o, pass_o, fail_o, timeout_o}, 64'd0);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (wb_ack_o) seen = 1'b1;
      end
      checkOutput("rst_stall_no_ack", 64'(seen), 64'd0);
      regRead(R_ST, rd, cnt);
      checkOutput("rst_stall_status", 64'(rd), 64'(statusModel(0)));

      // Random traffic against the model
      $display("[TB] random traffic");
      doReset();
      ready_mode = 2;
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 6))
            0, 1, 2: begin
               b   = 8'($urandom_range(2, 254));
               sel = ($urandom_range(0, 4) == 0) ? 4'b1110 : (4'($urandom_range(0, 15)) | 4'b0001);
               mboxWrite(b, sel, w);
            end
            3: begin
               regRead(R_ST, rd, cnt);
               checkOutput("rand_status_flags", 64'(rd & 32'hFFFF_00EF), 64'(statusModel(0) & 32'hFFFF_00EF));
               checkOutput("rand_full_vs_count", 64'(rd[4]), 64'(rd[15:8] == 8'(DEPTH)));
            end
            4: begin
               regRead(R_LO, rd, cnt);
               checkOutput("rand_cycle_lo", 64'(rd), 64'(cnt[31:0]));
               model_shadow = cnt[63:32];
            end
            5: begin
               regRead(R_HI, rd, cnt);
               checkOutput("rand_cycle_hi", 64'(rd), 64'(model_shadow));
            end
            default: begin
               applyStimulus(1'($urandom_range(0, 1)),
                             (($urandom_range(0, 1) == 0) ? (BASE + 32'h10) : (BASE ^ 32'h8000_0000))
                                | 32'($urandom_range(0, 15)),
                             $urandom, 4'hF, 4, rd, ack, w, cnt);
               checkOutput("outside_no_ack", 64'(ack), 64'd0);
            end
         endcase
      end
      waitDrain("rand_drain");

      // Timeout with no verdict
      $display("[TB] timeout");
      doReset();
      ready_mode = 0;
      w = 0;
      while (model_cycles != 64'(MAXC) && w < 2 * MAXC) begin
         @(negedge clk);
         w++;
      end
      checkOutput("timeout_reach", model_cycles, 64'(MAXC));
      checkOutput("timeout_before", 64'(timeout_o), 64'd0);
      @(negedge clk);
      m_done    = 1'b1;
      m_timeout = 1'b1;
      checkOutput("timeout_flags", {60'd0, done_o, pass_o, fail_o, timeout_o}, 64'b1001);
      regRead(R_ST, rd, cnt);
      checkOutput("status_timeout", 64'(rd), 64'(statusModel(0)));
      mboxWrite(8'h01, 4'b0001, w);
      mboxWrite(8'h33, 4'b0001, w);
      regRead(R_ST, rd, cnt);
      checkOutput("status_after_timeout_wr", 64'(rd), 64'(statusModel(0)));

      // Pass code lands in the very cycle the timeout fires
      $display("[TB] timeout versus pass");
      doReset();
      w = 0;
      while (model_cycles != 64'(MAXC) && w < 2 * MAXC) begin
         @(negedge clk);
         w++;
      end
      m_done    = 1'b1;
      m_timeout = 1'b1;
      regWrite(R_MB, 32'h0000_0001, 4'b0001, w);
      checkOutput("tie_flags", {60'd0, done_o, pass_o, fail_o, timeout_o}, 64'b1001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
